fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline: PC register, instruction memory, PC+4 adder and IF/ID pipeline latch.
//   Consumes stall_flag from the load-use hazard detector, and branch/jump redirects from the later stages.
//   Produces the IF/ID bundle read by decode. Detects HALT and freezes fetch; the debug unit gates it through enable.
// PARAMETERS
//   DATA_WIDTH      32            instruction / PC width
//   IMEM_ADDR_BITS  8             word-address bits of instruction memory (256 words)
//   PC_RESET        32'h0         PC value after reset
//   NOP_INSTR       32'h00000000  bubble written into IF/ID on flush and reset
//   HALT_OPCODE     6'b111111     opcode field [31:26] identifying HALT
// PORTS
//   clk             in   1               single clock, rising edge
//   rst_n           in   1               asynchronous active-low reset
//   enable          in   1               debug-unit run/step gate; 0 = all state holds
//   stall_flag      in   1               load-use stall from the hazard detector
//   pc_src          in   1               taken branch/jump: redirect PC and flush IF/ID
//   branch_target   in   DATA_WIDTH      redirect address, byte-addressed
//   imem_wr_en      in   1               program-load write strobe from the debug unit
//   imem_wr_addr    in   IMEM_ADDR_BITS  word address of the program-load write
//   imem_wr_data    in   DATA_WIDTH      program-load data
//   pc_out          out  DATA_WIDTH      current PC, for debug readout
//   if_id_instr     out  DATA_WIDTH      latched instruction for decode
//   if_id_pc_plus4  out  DATA_WIDTH      latched PC+4 of that instruction
//   if_id_valid     out  1               1 = if_id_instr is a real fetched instruction
//   halt_flag       out  1               sticky: HALT has been fetched
// BEHAVIOUR
//   - Reset (asynchronous, any time, including mid-stall):
//     pc_out=PC_RESET, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, halt_flag=0.
//     Memory contents are kept.
//   - Fetch: combinational read imem[pc_out[IMEM_ADDR_BITS+1:2]].
//     PC bits [1:0] are ignored. Upper bits alias; the PC is not range-checked.
//   - PC+4 is computed modulo 2^DATA_WIDTH: 32'hFFFFFFFC wraps to 0.
//   - Per rising edge, first matching rule wins:
//     1. enable=0: PC, IF/ID and halt_flag all hold.
//     2. pc_src=1: PC<=branch_target; IF/ID<=NOP_INSTR, valid=0; halt_flag<=0.
//        The redirect overrides a simultaneous stall, because the branch is older than the load.
//        It also cancels a wrong-path HALT.
//     3. stall_flag=1: PC and IF/ID hold.
//     4. halt_flag=1: PC and IF/ID hold. Decode sees the HALT stay in IF/ID.
//     5. Normal: IF/ID<={instr, PC+4}, valid=1.
//        If instr[31:26]==HALT_OPCODE: halt_flag<=1 and the PC holds. Otherwise PC<=PC+4.
//   - Latency: instruction at PC appears on if_id_* one cycle after PC is presented.
//     A redirect costs one bubble cycle.
//   - halt_flag is sticky. It clears only on reset, or on pc_src with enable=1.
//   - imem write: synchronous and honoured only when enable=0; ignored while running.
//     A write to the word currently addressed shows on the read port the next cycle.
// STRUCTURE
//   - Shared package: PC_RESET, NOP_INSTR, HALT_OPCODE, the opcode field slice [31:26], DATA_WIDTH.
//     Decode and the debug unit use the same values.
//   - One sub-module, instr_mem: IMEM_ADDR_BITS x DATA_WIDTH, async read, sync write, no reset.
//   - PC register, adder, IF/ID latch and halt flag live in fetch_stage.
// TESTING
//   1. Load imem 0..3 = {0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF}, enable=1.
//      -> if_id_pc_plus4 shows 4, 8, 12, 16. HALT latched. halt_flag=1 and pc_out stays 12.
//   2. stall_flag=1 for 2 cycles while pc_out=8.
//      -> pc_out stays 8 and IF/ID holds the word-1 instruction; fetch resumes with word 2.
//   3. pc_src=1 and stall_flag=1 together, branch_target=0x40.
//      -> next cycle pc_out=0x40, if_id_instr=NOP, if_id_valid=0.
//   4. HALT fetched at 12, then pc_src=1, target=0x20.
//      -> halt_flag=0, pc_out=0x20, fetch continues.
//   5. enable=0, write 0xDEADBEEF at addr 5, then a write with enable=1.
//      -> first write lands. The second is ignored. PC and IF/ID hold while enable=0.
//   6. Assert rst_n=0 mid-cycle during a stall.
//      -> outputs reach reset values immediately, without waiting for a clock edge; imem is unchanged.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared IF-stage constants, types and opcode helpers
// Used by fetch_stage, instr_mem, decode and the debug unit so that all agree
// on word width, reset PC, bubble encoding and the HALT opcode.
package fetch_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int IMEM_ADDR_BITS = 8;
    localparam int OPCODE_MSB     = 31;
    localparam int OPCODE_LSB     = 26;

    typedef logic [DATA_WIDTH-1:0]          word_t;
    typedef logic [IMEM_ADDR_BITS-1:0]      imem_addr_t;
    typedef logic [OPCODE_MSB-OPCODE_LSB:0] opcode_t;

    localparam word_t   PC_RESET    = 32'h0000_0000;
    localparam word_t   NOP_INSTR   = 32'h0000_0000;
    localparam opcode_t HALT_OPCODE = 6'b111111;

    typedef struct packed {
        word_t instr;
        word_t pc_plus4;
        logic  valid;
    } if_id_t;

    function automatic opcode_t opcode_of(input word_t instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic is_halt(input word_t instr);
        return opcode_of(instr) == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control, program-load and IF/ID signals of the fetch stage
// Ports: enable, stall_flag, pc_src, branch_target, imem_wr_en/addr/data (into fetch)
//        pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, halt_flag (out of fetch)
// slave = fetch_stage side, master = the pipeline/debug side driving it.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic       enable;
    logic       stall_flag;
    logic       pc_src;
    word_t      branch_target;
    logic       imem_wr_en;
    imem_addr_t imem_wr_addr;
    word_t      imem_wr_data;

    word_t      pc_out;
    word_t      if_id_instr;
    word_t      if_id_pc_plus4;
    logic       if_id_valid;
    logic       halt_flag;

    modport master (
        output enable, stall_flag, pc_src, branch_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        input  pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, halt_flag
    );

    modport slave (
        input  enable, stall_flag, pc_src, branch_target,
               imem_wr_en, imem_wr_addr, imem_wr_data,
        output pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, halt_flag
    );

endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory, async read, sync write, no reset
// Ports: clk; wr_en/wr_addr/wr_data (program load); rd_addr -> rd_data (combinational)
// Contents survive pipeline reset so a loaded program can be rerun.
module instr_mem
    import fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  imem_addr_t wr_addr,
    input  word_t      wr_data,
    input  imem_addr_t rd_addr,
    output word_t      rd_data
);

    word_t mem [0:(1<<IMEM_ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, instruction memory, PC+4 and IF/ID latch
// Ports: clk, rst_n (async, active low); bus (fetch_stage_if.slave):
//   in : enable, stall_flag, pc_src, branch_target, imem_wr_en/addr/data
//   out: pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, halt_flag
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);

    // A flush writes the same bubble as reset, so decode never sees a stale PC+4.
    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

    word_t  pc_q, pc_d;
    if_id_t if_id_q, if_id_d;
    logic   halt_q, halt_d;
    word_t  instr;
    word_t  pc_plus4;

    // Wraps naturally at 2^DATA_WIDTH.
    assign pc_plus4 = pc_q + word_t'(4);

    // Program load only while the debug unit has the pipeline stopped.
    instr_mem u_instr_mem (
        .clk     (clk),
        .wr_en   (bus.imem_wr_en & ~bus.enable),
        .wr_addr (bus.imem_wr_addr),
        .wr_data (bus.imem_wr_data),
        .rd_addr (pc_q[IMEM_ADDR_BITS+1:2]),
        .rd_data (instr)
    );

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        halt_d  = halt_q;
        if (bus.enable) begin
            if (bus.pc_src) begin
                // Branch is older than any stalled load and than a wrong-path HALT.
                pc_d    = bus.branch_target;
                if_id_d = BUBBLE;
                halt_d  = 1'b0;
            end else if (!bus.stall_flag && !halt_q) begin
                if_id_d = '{instr: instr, pc_plus4: pc_plus4, valid: 1'b1};
                if (is_halt(instr)) begin
                    // PC stays on the HALT so debug readout points at it.
                    halt_d = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RESET;
            if_id_q <= BUBBLE;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.if_id_instr    = if_id_q.instr;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.if_id_valid    = if_id_q.valid;
    assign bus.halt_flag      = halt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
    } stim_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pc;
        logic        halt;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } row_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk_row(input logic en, input logic stall, input logic src,
                                    input logic [31:0] tgt, input logic we, input logic [7:0] wa,
                                    input logic [31:0] wd, input logic [31:0] instr,
                                    input logic [31:0] pc4, input logic valid,
                                    input logic [31:0] pc, input logic halt);
        row_t r;
        r.s = '{en: en, stall: stall, src: src, tgt: tgt, we: we, wa: wa, wd: wd};
        r.e = '{instr: instr, pc4: pc4, valid: valid, pc: pc, halt: halt};
        return r;
    endfunction

    function automatic row_t run(input logic stall, input logic [31:0] instr,
                                 input logic [31:0] pc4, input logic [31:0] pc, input logic halt);
        return mk_row(1'b1, stall, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, instr, pc4, 1'b1, pc, halt);
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("instr=%h pc4=%h valid=%b pc=%h halt=%b", v.instr, v.pc4, v.valid, v.pc, v.halt);
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.instr = bus.if_id_instr;
        o.pc4   = bus.if_id_pc_plus4;
        o.valid = bus.if_id_valid;
        o.pc    = bus.pc_out;
        o.halt  = bus.halt_flag;
        return o;
    endfunction

    task automatic idle_inputs();
        bus.enable        = 1'b0;
        bus.stall_flag    = 1'b0;
        bus.pc_src        = 1'b0;
        bus.branch_target = 32'h0;
        bus.imem_wr_en    = 1'b0;
        bus.imem_wr_addr  = 8'h0;
        bus.imem_wr_data  = 32'h0;
    endtask

    task automatic apply(input row_t r);
        bus.enable        = r.s.en;
        bus.stall_flag    = r.s.stall;
        bus.pc_src        = r.s.src;
        bus.branch_target = r.s.tgt;
        bus.imem_wr_en    = r.s.we;
        bus.imem_wr_addr  = r.s.wa;
        bus.imem_wr_data  = r.s.wd;
        sb.push_back(r.e);
    endtask

    task automatic advance(output exp_t got, output exp_t want);
        @(posedge clk);
        #1;
        got  = observe();
        want = sb.pop_front();
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        bus.enable       = 1'b0;
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = a;
        bus.imem_wr_data = d;
        @(posedge clk);
        #1;
        bus.imem_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.pc_out !== PC_RESET) begin errors++; $display("FAIL reset_pc got %h want %h", bus.pc_out, PC_RESET); end
        checks++; if (bus.if_id_instr !== NOP_INSTR) begin errors++; $display("FAIL reset_instr got %h want %h", bus.if_id_instr, NOP_INSTR); end
        checks++; if (bus.if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0", bus.if_id_pc_plus4); end
        checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.if_id_valid); end
        checks++; if (bus.halt_flag !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", bus.halt_flag); end
        load_word(8'd0,   32'h20010005);
        load_word(8'd1,   32'h20020007);
        load_word(8'd2,   32'h00221820);
        load_word(8'd3,   32'hFFFFFFFF);
        load_word(8'd8,   32'h20030001);
        load_word(8'd16,  32'h20050003);
        load_word(8'd17,  32'h20060004);
        load_word(8'd255, 32'h20070007);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_halt();
        row_t rows[$];
        exp_t got, want;
        rows.push_back(run(1'b0, 32'h20010005, 32'd4,  32'd4,  1'b0));
        rows.push_back(run(1'b0, 32'h20020007, 32'd8,  32'd8,  1'b0));
        rows.push_back(run(1'b0, 32'h00221820, 32'd12, 32'd12, 1'b0));
        rows.push_back(run(1'b0, 32'hFFFFFFFF, 32'd16, 32'd12, 1'b1));
        rows.push_back(run(1'b0, 32'hFFFFFFFF, 32'd16, 32'd12, 1'b1));
        rows.push_back(run(1'b1, 32'hFFFFFFFF, 32'd16, 32'd12, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL fetch_halt row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        exp_t got, want;
        pulse_reset();
        rows.push_back(run(1'b0, 32'h20010005, 32'd4,  32'd4,  1'b0));
        rows.push_back(run(1'b0, 32'h20020007, 32'd8,  32'd8,  1'b0));
        rows.push_back(run(1'b1, 32'h20020007, 32'd8,  32'd8,  1'b0));
        rows.push_back(run(1'b1, 32'h20020007, 32'd8,  32'd8,  1'b0));
        rows.push_back(run(1'b0, 32'h00221820, 32'd12, 32'd12, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL stall row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_redirect_over_stall();
        row_t rows[$];
        exp_t got, want;
        rows.push_back(mk_row(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 8'h0, 32'h0, NOP_INSTR, 32'h0, 1'b0, 32'h40, 1'b0));
        rows.push_back(run(1'b0, 32'h20050003, 32'h44, 32'h44, 1'b0));
        rows.push_back(run(1'b0, 32'h20060004, 32'h48, 32'h48, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL redirect_stall row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_halt_cancel();
        row_t rows[$];
        exp_t got, want;
        pulse_reset();
        rows.push_back(run(1'b0, 32'h20010005, 32'd4,  32'd4,  1'b0));
        rows.push_back(run(1'b0, 32'h20020007, 32'd8,  32'd8,  1'b0));
        rows.push_back(run(1'b0, 32'h00221820, 32'd12, 32'd12, 1'b0));
        rows.push_back(run(1'b0, 32'hFFFFFFFF, 32'd16, 32'd12, 1'b1));
        // A redirect while the debug unit holds the pipeline must not clear HALT.
        rows.push_back(mk_row(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 8'h0, 32'h0, 32'hFFFFFFFF, 32'd16, 1'b1, 32'd12, 1'b1));
        rows.push_back(mk_row(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 8'h0, 32'h0, NOP_INSTR, 32'h0, 1'b0, 32'h20, 1'b0));
        rows.push_back(run(1'b0, 32'h20030001, 32'h24, 32'h24, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL halt_cancel row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_enable_gate();
        row_t rows[$];
        exp_t got, want;
        rows.push_back(mk_row(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 8'd5, 32'hDEADBEEF, 32'h20030001, 32'h24, 1'b1, 32'h24, 1'b0));
        rows.push_back(mk_row(1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 8'd5, 32'h11111111, NOP_INSTR, 32'h0, 1'b0, 32'h14, 1'b0));
        rows.push_back(run(1'b0, 32'hDEADBEEF, 32'h18, 32'h18, 1'b0));
        rows.push_back(mk_row(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 8'd6, 32'h22222222, 32'hDEADBEEF, 32'h18, 1'b1, 32'h18, 1'b0));
        rows.push_back(run(1'b0, 32'h22222222, 32'h1C, 32'h1C, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL enable_gate row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_pc_wrap();
        row_t rows[$];
        exp_t got, want;
        rows.push_back(mk_row(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 8'h0, 32'h0, NOP_INSTR, 32'h0, 1'b0, 32'hFFFFFFFC, 1'b0));
        rows.push_back(run(1'b0, 32'h20070007, 32'h0, 32'h0, 1'b0));
        rows.push_back(run(1'b0, 32'h20010005, 32'd4, 32'd4, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL pc_wrap row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_async_reset();
        row_t rows[$];
        exp_t got, want;
        apply(run(1'b1, 32'h20010005, 32'd4, 32'd4, 1'b0));
        advance(got, want);
        checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset_pre got %s want %s", fmt(got), fmt(want)); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        want = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0, pc: PC_RESET, halt: 1'b0};
        got  = observe();
        checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset_mid got %s want %s", fmt(got), fmt(want)); end
        #1;
        rst_n = 1'b1;
        rows.push_back(run(1'b0, 32'h20010005, 32'd4, 32'd4, 1'b0));
        rows.push_back(run(1'b0, 32'h20020007, 32'd8, 32'd8, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            advance(got, want);
            checks++;
            if (got !== want) begin errors++; $display("FAIL async_reset_post row%0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_halt();
        test_stall();
        test_redirect_over_stall();
        test_halt_cancel();
        test_enable_gate();
        test_pc_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
